// File: rtl/cim_ibuf.sv
// Input buffer for the crossbar controller: packs word-serial activations into vectors,
// queues them in a small FIFO and offers the head vector via start/busy. Optional: CIM_IBUF_LAST_EN.
module cim_ibuf #(
    parameter int unsigned datatype_size = 8,
    parameter int unsigned input_size    = 5,
    parameter int unsigned fifo_length   = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [datatype_size-1:0]         i_data,
`ifdef CIM_IBUF_LAST_EN
    input  logic                             i_last,
`endif
    output logic                             o_start,
    input  logic                             i_busy,
    output logic [datatype_size-1:0]         o_data [input_size-1:0],
    output logic [$clog2(fifo_length+1)-1:0] o_count,
    output logic                             o_full,
    output logic                             o_empty
);

    localparam int unsigned CW = $clog2(fifo_length + 1);
    localparam int unsigned PW = (fifo_length > 1) ? $clog2(fifo_length) : 1;
    localparam int unsigned IW = (input_size > 1) ? $clog2(input_size) : 1;

    typedef logic [input_size-1:0][datatype_size-1:0] vec_t;
    typedef enum logic [1:0] {S_IDLE, S_OFFER, S_WAIT} state_t;

    state_t        state_q, state_d;
    vec_t          asm_q, asm_d;
    vec_t          push_vec;
    vec_t          mem_q [fifo_length];
    vec_t          data_q, data_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;
    logic          accept;
    logic          last_word;
    logic          push;
    logic          pop;

    assign o_full  = (count_q == CW'(fifo_length));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_ready = !o_full && !rst;
    assign o_start = (state_q == S_OFFER);

    always_comb begin
        for (int unsigned i = 0; i < input_size; i++) begin
            o_data[i] = data_q[i];
        end
    end

    // Write side: the completing word is merged into the vector that gets pushed.
    always_comb begin
        accept    = i_valid && o_ready;
        last_word = (wr_idx_q == IW'(input_size - 1));
`ifdef CIM_IBUF_LAST_EN
        last_word = last_word || i_last;
`endif
        push  = accept && last_word;
        asm_d = asm_q;
        if (accept) begin
            asm_d[wr_idx_q] = i_data;
        end
        push_vec = asm_d;
`ifdef CIM_IBUF_LAST_EN
        for (int unsigned i = 0; i < input_size; i++) begin
            if (i > 32'(wr_idx_q)) begin
                push_vec[i] = '0;
            end
        end
`endif
        wr_idx_d = wr_idx_q;
        if (accept) begin
            wr_idx_d = push ? '0 : wr_idx_q + IW'(1);
        end
    end

    // Read-side handshake with the controller.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!o_empty && !i_busy) begin
                    state_d = S_OFFER;
                end
            end
            S_OFFER: begin
                if (i_busy) begin
                    state_d = S_WAIT;
                    pop     = 1'b1;
                end
            end
            S_WAIT: begin
                if (!i_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (push) begin
            wp_d = (wp_q == PW'(fifo_length - 1)) ? '0 : wp_q + PW'(1);
        end
        if (pop) begin
            rp_d = (rp_q == PW'(fifo_length - 1)) ? '0 : rp_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        // Head vector is frozen while it is being offered.
        data_d = (state_q == S_OFFER) ? data_q : mem_q[rp_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            asm_q    <= '0;
            wr_idx_q <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            count_q  <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            asm_q    <= asm_d;
            wr_idx_q <= wr_idx_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            count_q  <= count_d;
            data_q   <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < fifo_length; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wp_q] <= push_vec;
        end
    end

endmodule

// File: tb/tb_cim_ibuf.sv
// Scoreboard bench for cim_ibuf: the driver records expected vectors as words are accepted,
// a monitor checks offered vectors and occupancy flags against a count-based model.
`timescale 1ns/1ps
module tb_cim_ibuf;

    localparam int unsigned DW = 8;
    localparam int unsigned IS = 5;
    localparam int unsigned FL = 4;
    localparam int unsigned CW = $clog2(FL + 1);
`ifdef CIM_IBUF_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data;
`ifdef CIM_IBUF_LAST_EN
    logic          i_last;
`endif
    logic          o_start;
    logic          i_busy;
    logic [DW-1:0] o_data [IS-1:0];
    logic [CW-1:0] o_count;
    logic          o_full;
    logic          o_empty;

    logic          busy_man;
    logic          busy_auto;
    bit            ctrl_auto;
    bit            chk_en;

    int            checks = 0;
    int            errors = 0;
    int            push_cnt = 0;
    int            pop_cnt = 0;
    logic [IS*DW-1:0] exp_q [$];
    logic [DW-1:0] asm_m [IS];
    int            widx = 0;

    assign i_busy = ctrl_auto ? busy_auto : busy_man;

    always #5 clk = ~clk;

    cim_ibuf #(
        .datatype_size(DW),
        .input_size   (IS),
        .fifo_length  (FL)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_data (i_data),
`ifdef CIM_IBUF_LAST_EN
        .i_last (i_last),
`endif
        .o_start(o_start),
        .i_busy (i_busy),
        .o_data (o_data),
        .o_count(o_count),
        .o_full (o_full),
        .o_empty(o_empty)
    );

    function automatic int model_count();
        return push_cnt - pop_cnt;
    endfunction

    function automatic logic [IS*DW-1:0] pack_out();
        logic [IS*DW-1:0] v;
        for (int i = 0; i < int'(IS); i++) v[i*DW +: DW] = o_data[i];
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference packing: collect words, emit a zero-padded vector on completion.
    task automatic model_accept(input logic [DW-1:0] d, input bit last);
        logic [IS*DW-1:0] v;
        asm_m[widx] = d;
        if (widx == int'(IS) - 1 || (LAST_EN && last)) begin
            v = '0;
            for (int i = 0; i <= widx; i++) v[i*DW +: DW] = asm_m[i];
            exp_q.push_back(v);
            push_cnt++;
            widx = 0;
        end else begin
            widx++;
        end
    endtask

    task automatic send_word(input logic [DW-1:0] d, input bit last, input int budget);
        bit acc;
        int w;
        acc = 1'b0;
        w = 0;
        i_valid = 1'b1;
        i_data  = d;
`ifdef CIM_IBUF_LAST_EN
        i_last  = last;
`endif
        while (!acc && w < budget) begin
            @(negedge clk);
            acc = o_ready;
            @(posedge clk);
            w++;
        end
        if (acc) begin
            model_accept(d, last);
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word 0x%0h not accepted, o_ready=%0b, expected 1 within %0d cycles", d, o_ready, budget);
        end
        #1;
        i_valid = 1'b0;
`ifdef CIM_IBUF_LAST_EN
        i_last  = 1'b0;
`endif
    endtask

    task automatic do_reset();
        chk_en  = 1'b0;
        i_valid = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        check("rst_start", 64'(o_start), 64'(0));
        check("rst_count", 64'(o_count), 64'(0));
        check("rst_empty", 64'(o_empty), 64'(1));
        check("rst_full",  64'(o_full),  64'(0));
        check("rst_ready", 64'(o_ready), 64'(0));
        check("rst_data",  64'(pack_out()), 64'(0));
        exp_q.delete();
        push_cnt = pop_cnt;
        widx = 0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
    endtask

    task automatic wait_start(input string name, input int budget);
        int w;
        w = 0;
        while (!o_start && w < budget) begin
            @(posedge clk);
            #1;
            w++;
        end
        check(name, 64'(o_start), 64'(1));
    endtask

    task automatic handoff(input int budget);
        wait_start("handoff_start", budget);
        busy_man = 1'b1;
        @(posedge clk);
        #1;
        check("handoff_start_fall", 64'(o_start), 64'(0));
        busy_man = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int w;
        w = 0;
        while ((model_count() != 0 || exp_q.size() != 0) && w < budget) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w >= budget) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d vectors still pending, expected 0", exp_q.size());
        end
        check("drain_count", 64'(o_count), 64'(0));
        repeat (10) @(posedge clk);
        #1;
        ctrl_auto = 1'b0;
        busy_man  = 1'b0;
    endtask

    // Monitor: checks occupancy every cycle and each offered vector against the scoreboard.
    initial begin : monitor
        bit pend;
        bit prev_start;
        logic [IS*DW-1:0] held;
        pend = 1'b0;
        prev_start = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            pend = 1'b0;
            if (chk_en) begin
                check("count", 64'(o_count), 64'(model_count()));
                check("full",  64'(o_full),  64'(model_count() == int'(FL)));
                check("empty", 64'(o_empty), 64'(model_count() == 0));
                check("ready", 64'(o_ready), 64'(model_count() != int'(FL)));
                if (o_start) begin
                    if (!prev_start) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL offer_unexpected: o_start=1, expected 0 (no vector pending)");
                        end else begin
                            held = exp_q.pop_front();
                            check("offer_data", 64'(pack_out()), 64'(held));
                        end
                    end else begin
                        check("data_stable", 64'(pack_out()), 64'(held));
                    end
                end
                pend = o_start && i_busy;
                prev_start = o_start;
            end else begin
                prev_start = 1'b0;
            end
            @(posedge clk);
            if (pend) pop_cnt++;
        end
    end

    // Controller emulation: acknowledges each offer after a random delay.
    initial begin : ctrl_model
        busy_auto = 1'b0;
        forever begin
            @(negedge clk);
            if (ctrl_auto && o_start) begin
                int d;
                d = $urandom_range(0, 2);
                repeat (d) @(posedge clk);
                @(posedge clk);
                #1 busy_auto = 1'b1;
                d = $urandom_range(1, 4);
                repeat (d) @(posedge clk);
                #1 busy_auto = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        rst       = 1'b1;
        i_valid   = 1'b0;
        i_data    = '0;
`ifdef CIM_IBUF_LAST_EN
        i_last    = 1'b0;
`endif
        busy_man  = 1'b0;
        ctrl_auto = 1'b0;
        chk_en    = 1'b0;
        do_reset();

        // Basic packing and latency.
        for (int i = 1; i <= 5; i++) send_word(DW'(i), 1'b0, 4);
        check("t1_count", 64'(o_count), 64'(1));
        check("t1_start_early", 64'(o_start), 64'(0));
        wait_start("t1_start", 2);
        busy_man = 1'b1;
        @(posedge clk);
        #1;
        check("t1_start_fall", 64'(o_start), 64'(0));
        check("t1_count_pop", 64'(o_count), 64'(0));
        busy_man = 1'b0;
        @(posedge clk);
        #1;

        // Fill while controller is busy: no offer, FIFO fills, extra word stalls.
        busy_man = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(FL * IS); i++) send_word(DW'(8'h40 + i), 1'b0, 4);
        check("t2_full", 64'(o_full), 64'(1));
        check("t2_ready", 64'(o_ready), 64'(0));
        check("t2_no_offer", 64'(o_start), 64'(0));
        i_valid = 1'b1;
        i_data  = 8'hEE;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("t2_stall_ready", 64'(o_ready), 64'(0));
            check("t2_stall_count", 64'(o_count), 64'(FL));
        end
        i_valid = 1'b0;
        ctrl_auto = 1'b1;
        busy_man  = 1'b0;
        for (int i = 0; i < int'(IS); i++) send_word(DW'(8'h90 + i), 1'b0, 40);
        wait_drain(400);

        // Push and pop on the same edge.
        for (int i = 0; i < int'(IS); i++) send_word(DW'(8'hA0 + i), 1'b0, 4);
        wait_start("t3_a_start", 4);
        for (int i = 0; i < int'(IS) - 1; i++) send_word(DW'(8'hB0 + i), 1'b0, 4);
        busy_man = 1'b1;
        send_word(DW'(8'hB0 + IS - 1), 1'b0, 1);
        check("t3_count_same", 64'(o_count), 64'(1));
        check("t3_start_fall", 64'(o_start), 64'(0));
        busy_man = 1'b0;
        handoff(6);

        // Reset mid-vector and mid-offer.
        for (int i = 0; i < 3; i++) send_word(DW'(8'hC0 + i), 1'b0, 4);
        do_reset();
        for (int i = 0; i < int'(IS); i++) send_word(DW'(8'hD0 + i), 1'b0, 4);
        wait_start("t4_offer", 4);
        do_reset();
        for (int i = 0; i < int'(IS); i++) send_word(DW'(8'h30 + i), 1'b0, 4);
        handoff(6);

        // Pointer wrap: ten vectors through a four-entry FIFO.
        ctrl_auto = 1'b1;
        for (int k = 0; k < 10; k++)
            for (int i = 0; i < int'(IS); i++) send_word(DW'(k * 10 + i), 1'b0, 60);
        wait_drain(400);

        // Random traffic with gaps and random controller timing.
        ctrl_auto = 1'b1;
        for (int v = 0; v < 40; v++) begin
            int unsigned n;
            bit lst;
            n = IS;
            if (LAST_EN && $urandom_range(0, 2) == 0) n = $urandom_range(1, IS);
            for (int unsigned i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                lst = LAST_EN && (i == n - 1) && (n != IS || $urandom_range(0, 1) == 1);
                send_word(DW'($urandom), lst, 60);
            end
        end
        wait_drain(600);

`ifdef CIM_IBUF_LAST_EN
        // Early completion pads the remaining elements with zero.
        send_word(DW'(7), 1'b0, 4);
        send_word(DW'(8), 1'b1, 4);
        check("t6_count", 64'(o_count), 64'(1));
        handoff(6);
        send_word(DW'(9), 1'b1, 4);
        handoff(6);
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
